fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter that shares one FIFO write port among N_REQ producers.
//   - Each producer has a valid/ready interface; the arbiter drives the FIFO's w_en/data_in.
//   - It honours the FIFO full flag and bounds each grant to MAX_BURST beats for fairness.
//   - Sits directly in front of the team FIFO (w_en, data_in, full).
// PARAMETERS
//   WIDTH      8   data width per beat; must equal the FIFO WIDTH
//   N_REQ      4   number of requesters, >=2
//   MAX_BURST  4   max beats per grant, >=1
//   CNT_W      16  width of per-requester statistics counters (ARB_STATS_EN only)
// PORTS
//   clk           in   1                  clock, all logic on posedge
//   rstn          in   1                  asynchronous active-low reset
//   req_valid     in   N_REQ              requester i has a beat on req_data slice i
//   req_data      in   N_REQ*WIDTH        packed; requester i at [i*WIDTH +: WIDTH]
//   req_ready     out  N_REQ              one-hot or zero; beat i accepted when valid&ready
//   fifo_w_en     out  1                  write strobe to FIFO
//   fifo_data_in  out  WIDTH              write data to FIFO
//   fifo_full     in   1                  FIFO full flag
//   grant_id      out  $clog2(N_REQ)      current owner index
//   busy          out  1                  1 while in GRANT state
//   stat_sel      in   $clog2(N_REQ)      statistics counter select
//   stat_count    out  CNT_W              selected statistics counter
// BEHAVIOUR
//   Reset (async, rstn=0):
//     - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
//     - Hence fifo_w_en=0, req_ready=0, busy=0, grant_id=0, fifo_data_in=0, stats cleared.
//     - Takes effect immediately, including mid-burst; no partial beat is written after assertion.
//   FSM states: IDLE, GRANT.
//     - IDLE: if |req_valid, owner <= first i with req_valid[i], searched from rr_ptr upward
//       modulo N_REQ; beat_cnt <= 0; go GRANT. Otherwise stay IDLE.
//     - Arbitration costs exactly one IDLE cycle per grant (one-cycle bubble between grants).
//     - GRANT:
//       - transfer = req_valid[owner] & ~fifo_full; beat_cnt increments on each transfer.
//       - Release when req_valid[owner]=0 (no transfer that cycle), or on the transfer
//         that makes beat_cnt==MAX_BURST.
//       - On release: rr_ptr <= (owner+1) mod N_REQ, go IDLE.
//       - fifo_full=1 stalls: no transfer, no release, owner and beat_cnt held.
//   Outputs (combinational from registered state):
//     - req_ready[i] = (state==GRANT) & (i==owner) & ~fifo_full.
//     - fifo_w_en = (state==GRANT) & req_valid[owner] & ~fifo_full.
//     - fifo_data_in = req_data slice of owner when state==GRANT, else 0.
//     - grant_id = owner; busy = (state==GRANT).
//   Boundaries:
//     - rr_ptr wraps N_REQ-1 -> 0.
//     - A requester raising valid in the release cycle is seen in the next IDLE cycle.
//     - fifo_full toggling on the last beat: the beat transfers only when full=0.
//     - The FIFO never sees w_en while full=1.
// CONFIGURATION
//   ARB_STATS_EN defined:
//     - One CNT_W-bit counter per requester, +1 on each transfer by that requester.
//     - Counters saturate at all-ones (no wrap) and are cleared only by reset.
//     - stat_count = counter[stat_sel], combinational.
//   ARB_STATS_EN undefined:
//     - No counters; stat_sel ignored; stat_count tied to 0. Ports remain present.
// TESTING (defaults)
//   1. Requester 2 holds valid for 6 beats -> 1 IDLE cycle, 4 writes (grant_id=2), IDLE, 2 writes.
//   2. All 4 valid continuously, 16 beats -> grant order 0,1,2,3, 4 beats each, 1 bubble between.
//   3. fifo_full=1 for 3 cycles after 2nd beat of owner 0 -> fifo_w_en=0, req_ready=0, owner held;
//      beats 3-4 follow, total 4 beats.
//   4. Owner 1 drops valid after 2 beats, req 0 and 2 valid -> release; next grant_id=2 (not 0).
//   5. rstn=0 mid-burst -> same cycle fifo_w_en=0, req_ready=0, busy=0, grant_id=0;
//      after release, first grant goes to lowest valid index.
//   6. ARB_STATS_EN, after test 2 -> stat_sel=1 gives stat_count=4.
//      Without ARB_STATS_EN -> stat_count=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Optional per-requester transfer counters are enabled with `define ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16,
    localparam int IDX_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_w_en,
    output logic [WIDTH-1:0]       fifo_data_in,
    input  logic                   fifo_full,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   busy,
    input  logic [IDX_W-1:0]       stat_sel,
    output logic [CNT_W-1:0]       stat_count
);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [BC_W-1:0]  beat_inc;
    logic             xfer;
    logic             found;
    int               scan_idx;

    assign xfer     = (state_q == GRANT) & req_valid[owner_q] & ~fifo_full;
    assign beat_inc = beat_cnt_q + BC_W'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        found      = 1'b0;
        scan_idx   = 0;
        case (state_q)
            IDLE: begin
                // Scan upward from rr_ptr, wrapping; first valid requester wins.
                for (int k = 0; k < N_REQ; k++) begin
                    scan_idx = int'(rr_ptr_q) + k;
                    if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
                    if (!found && req_valid[scan_idx]) begin
                        found   = 1'b1;
                        owner_d = IDX_W'(scan_idx);
                    end
                end
                beat_cnt_d = '0;
                if (found) state_d = GRANT;
            end
            GRANT: begin
                if (!fifo_full) begin
                    if (!req_valid[owner_q] || beat_inc == BC_W'(MAX_BURST)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    end
                    if (req_valid[owner_q]) beat_cnt_d = beat_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy         = (state_q == GRANT);
    assign grant_id     = owner_q;
    assign fifo_w_en    = xfer;
    assign fifo_data_in = busy ? req_data[int'(owner_q)*WIDTH +: WIDTH] : '0;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (busy && owner_q == IDX_W'(i) && !fifo_full) req_ready[i] = 1'b1;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] stat_q [N_REQ];
    logic [CNT_W-1:0] stat_d [N_REQ];

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        stat_d = stat_q;
        if (xfer && stat_q[owner_q] != '1) stat_d[owner_q] = stat_q[owner_q] + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_REQ; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_count = (int'(stat_sel) < N_REQ) ? stat_q[stat_sel] : '0;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default parameters), using immediate assertions.
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
    logic [1:0]  stat_sel;
    logic [15:0] stat_count;

    int n_asserts = 0;
    int n_fail    = 0;

    fifo_wr_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(4), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy),
        .stat_sel(stat_sel), .stat_count(stat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic b, input logic w, input int gid,
                       input logic [3:0] rdy, input logic [7:0] d);
        #1;
        chk({tag, " busy"},  32'(busy),         32'(b));
        chk({tag, " w_en"},  32'(fifo_w_en),    32'(w));
        chk({tag, " gid"},   32'(grant_id),     32'(gid));
        chk({tag, " ready"}, 32'(req_ready),    32'(rdy));
        chk({tag, " data"},  32'(fifo_data_in), 32'(d));
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst busy",  32'(busy),         32'd0);
        chk("rst w_en",  32'(fifo_w_en),    32'd0);
        chk("rst ready", 32'(req_ready),    32'd0);
        chk("rst gid",   32'(grant_id),     32'd0);
        chk("rst data",  32'(fifo_data_in), 32'd0);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        req_data  = 32'h44332211;
        fifo_full = 1'b0;
        stat_sel  = '0;
        tick();
        do_reset();

        // Test 1: requester 2 streams 6 beats.
        req_valid = 4'b0100;
        cyc("t1 arb", 0, 0, 0, 4'b0000, 8'h00);
        for (int b = 0; b < 4; b++) cyc("t1 burst1", 1, 1, 2, 4'b0100, 8'h33);
        cyc("t1 bubble", 0, 0, 2, 4'b0000, 8'h00);
        for (int b = 0; b < 2; b++) cyc("t1 burst2", 1, 1, 2, 4'b0100, 8'h33);
        req_valid = 4'b0000;
        cyc("t1 drop", 1, 0, 2, 4'b0100, 8'h33);
        cyc("t1 idle", 0, 0, 2, 4'b0000, 8'h00);

        // Test 2: all requesters valid, expect 0,1,2,3 with 4 beats each.
        do_reset();
        req_valid = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            cyc("t2 bubble", 0, 0, (r == 0) ? 0 : r - 1, 4'b0000, 8'h00);
            for (int b = 0; b < 4; b++)
                cyc("t2 burst", 1, 1, r, 4'(1 << r), 8'(8'h11 * (r + 1)));
        end
        req_valid = 4'b0000;
        cyc("t2 idle", 0, 0, 3, 4'b0000, 8'h00);
        stat_sel = 2'd1;
        #1;
`ifdef ARB_STATS_EN
        chk("t2 stat1", 32'(stat_count), 32'd4);
`else
        chk("t2 stat1", 32'(stat_count), 32'd0);
`endif

        // Test 3: fifo_full stalls owner 0 for 3 cycles after its 2nd beat.
        req_valid = 4'b0001;
        cyc("t3 arb", 0, 0, 3, 4'b0000, 8'h00);
        for (int b = 0; b < 2; b++) cyc("t3 beat12", 1, 1, 0, 4'b0001, 8'h11);
        fifo_full = 1'b1;
        for (int b = 0; b < 3; b++) cyc("t3 stall", 1, 0, 0, 4'b0000, 8'h11);
        fifo_full = 1'b0;
        for (int b = 0; b < 2; b++) cyc("t3 beat34", 1, 1, 0, 4'b0001, 8'h11);
        req_valid = 4'b0000;
        cyc("t3 released", 0, 0, 0, 4'b0000, 8'h00);

        // Test 4: owner 1 drops after 2 beats; next grant skips 0 and goes to 2.
        req_valid = 4'b0111;
        cyc("t4 arb", 0, 0, 0, 4'b0000, 8'h00);
        for (int b = 0; b < 2; b++) cyc("t4 beat", 1, 1, 1, 4'b0010, 8'h22);
        req_valid = 4'b0101;
        cyc("t4 drop", 1, 0, 1, 4'b0010, 8'h22);
        cyc("t4 bubble", 0, 0, 1, 4'b0000, 8'h00);
        cyc("t4 next", 1, 1, 2, 4'b0100, 8'h33);

        // Test 5: reset mid-burst of owner 2, then lowest valid index wins.
        do_reset();
        stat_sel = 2'd1;
        #1;
        chk("t5 stat cleared", 32'(stat_count), 32'd0);
        cyc("t5 arb", 0, 0, 0, 4'b0000, 8'h00);
        cyc("t5 grant", 1, 1, 0, 4'b0001, 8'h11);
        stat_sel = 2'd0;
        #1;
`ifdef ARB_STATS_EN
        chk("t5 stat0", 32'(stat_count), 32'd1);
`else
        chk("t5 stat0", 32'(stat_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
